// File: rtl/uctl_fifo_rd_unpacker.sv
// Byte unpacker for the uctl async FIFO read side: pops {eop, vldBytes, data} words and streams bytes.
// Optional build macro UCTL_UNPACK_MSB_FIRST_EN selects MSB-first byte order within each word.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no word held; pop the FIFO head as soon as it is non-empty
// SHIFT | word held in word_q; presenting byte idx on out_data
module uctl_fifo_rd_unpacker #(
    parameter int BYTES   = 4,
    parameter int BCNT_W  = 2,
    parameter int ENTRY_W = 35,
    parameter int LEN_W   = 11
) (
    input  logic               rclk,
    input  logic               rrst_n,
    input  logic               swRst,
    input  logic               fifo_rempty,
    input  logic [ENTRY_W-1:0] fifo_data,
    output logic               fifo_r_en,
    output logic [7:0]         out_data,
    output logic               out_valid,
    output logic               out_last,
    input  logic               out_ready,
    output logic [LEN_W-1:0]   pkt_len,
    output logic               pkt_done
);

    localparam int DATA_W = 8 * BYTES;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] word_q;
    logic [BCNT_W:0]   nbytes;
    logic [BCNT_W-1:0] idx;
    logic              eop_q;
    logic [LEN_W-1:0]  len_cnt;

    logic              ent_eop;
    logic [BCNT_W-1:0] ent_vld;
    logic [BCNT_W:0]   ent_cnt;
    logic              last_idx;
    logic              accept;
    logic              word_end;
    logic              load;
    logic [BCNT_W-1:0] sel;
    logic [DATA_W-1:0] word_shifted;
    logic [LEN_W-1:0]  len_inc;

    assign ent_eop = fifo_data[ENTRY_W-1];
    assign ent_vld = fifo_data[ENTRY_W-2:DATA_W];
    // vldBytes only means something on eop words; zero encodes a full word
    assign ent_cnt = (!ent_eop || (ent_vld == '0)) ? (BCNT_W+1)'(BYTES) : {1'b0, ent_vld};

    assign last_idx = ({1'b0, idx} == (nbytes - (BCNT_W+1)'(1)));
    assign accept   = (state == SHIFT) && out_ready;
    assign word_end = accept && last_idx;
    assign load     = !fifo_rempty && ((state == IDLE) || word_end);
    assign len_inc  = (len_cnt == '1) ? len_cnt : len_cnt + LEN_W'(1);

`ifdef UCTL_UNPACK_MSB_FIRST_EN
    assign sel = BCNT_W'(BYTES - 1) - idx;
`else
    assign sel = idx;
`endif
    assign word_shifted = word_q >> {sel, 3'b000};

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state <= IDLE;
        end else if (swRst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = SHIFT;
            SHIFT:   if (word_end && fifo_rempty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fifo_r_en = load && !swRst;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        if (state == SHIFT) begin
            out_valid = 1'b1;
            out_data  = word_shifted[7:0];
            out_last  = eop_q && last_idx;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            word_q   <= '0;
            nbytes   <= '0;
            idx      <= '0;
            eop_q    <= 1'b0;
            len_cnt  <= '0;
            pkt_len  <= '0;
            pkt_done <= 1'b0;
        end else if (swRst) begin
            word_q   <= '0;
            nbytes   <= '0;
            idx      <= '0;
            eop_q    <= 1'b0;
            len_cnt  <= '0;
            pkt_len  <= '0;
            pkt_done <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            if (load) begin
                word_q <= fifo_data[DATA_W-1:0];
                nbytes <= ent_cnt;
                eop_q  <= ent_eop;
                idx    <= '0;
            end else if (accept) begin
                idx <= idx + BCNT_W'(1);
            end
            if (accept) begin
                if (eop_q && last_idx) begin
                    pkt_len  <= len_inc;
                    pkt_done <= 1'b1;
                    len_cnt  <= '0;
                end else begin
                    len_cnt <= len_inc;
                end
            end
        end
    end

endmodule
